// File: rtl/arb4_rr.sv
// arb4_rr: four-client round-robin arbiter with burst hold.
// Registered grant; preempt pulses when the burst limit forces a handover.
module arb4_rr #(
  parameter  int MAX_BURST = 8,
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic [1:0] gnt_id,
  output logic       preempt
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [1:0]       r_ptr, w_ptr_nx;
  logic [1:0]       r_id, w_id_nx;
  logic [3:0]       r_gnt, w_gnt_nx;
  logic             r_valid;
  logic             r_pre, w_pre_nx;

  logic [2:0]       w_pick;
  logic             w_hold;
  logic             w_others;
  logic             w_at_max;

  // First requester at offset 0..3 from p; bit 2 flags a hit.
  function automatic logic [2:0] rr_pick(
    input logic [3:0] r,
    input logic [1:0] p
  );
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // In GRANT the pointer is the owner, so one pick serves both states.
  assign w_pick   = rr_pick(req, r_ptr + 2'd1);
  assign w_hold   = req[r_ptr];
  assign w_others = |(req & ~(4'b0001 << r_ptr));
  assign w_at_max = (r_cnt == C_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= 2'd3;
      r_id    <= 2'd0;
      r_gnt   <= 4'b0000;
      r_valid <= 1'b0;
      r_pre   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_ptr   <= w_ptr_nx;
      r_id    <= w_id_nx;
      r_gnt   <= w_gnt_nx;
      r_valid <= |w_gnt_nx;
      r_pre   <= w_pre_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_ptr_nx   = r_ptr;
    w_id_nx    = r_id;
    w_gnt_nx   = r_gnt;
    w_pre_nx   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_gnt_nx = 4'b0000;
        if (w_pick[2]) begin
          w_state_nx = S_GRANT;
          w_cnt_nx   = C_ONE;
          w_ptr_nx   = w_pick[1:0];
          w_id_nx    = w_pick[1:0];
          w_gnt_nx   = 4'b0001 << w_pick[1:0];
        end
      end
      S_GRANT: begin
        unique case (1'b1)
          !w_hold && w_pick[2],
          w_hold && w_at_max && w_others: begin
            w_cnt_nx = C_ONE;
            w_ptr_nx = w_pick[1:0];
            w_id_nx  = w_pick[1:0];
            w_gnt_nx = 4'b0001 << w_pick[1:0];
            w_pre_nx = w_hold;
          end
          !w_hold && !w_pick[2]: begin
            w_state_nx = S_IDLE;
            w_gnt_nx   = 4'b0000;
          end
          w_hold && !w_at_max: begin
            w_cnt_nx = r_cnt + C_ONE;
          end
          w_hold && w_at_max && !w_others: begin
            w_cnt_nx = C_ONE;
          end
        endcase
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    gnt       = r_gnt;
    gnt_valid = r_valid;
    gnt_id    = r_id;
    preempt   = r_pre;
  end

endmodule

// File: tb/tb_arb4_rr.sv
// tb_arb4_rr: directed vectors into a scoreboard queue,
// checked by an independent negedge monitor.
module tb_arb4_rr;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req8 = 4'b0000;
  logic [3:0] req1 = 4'b0000;

  logic [3:0] gnt8, gnt1;
  logic       v8, v1;
  logic [1:0] id8, id1;
  logic       p8, p1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit         d;
    logic [3:0] g;
    logic       v;
    logic [1:0] id;
    logic       p;
    string      nm;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  arb4_rr #(.MAX_BURST(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .req       (req8),
    .gnt       (gnt8),
    .gnt_valid (v8),
    .gnt_id    (id8),
    .preempt   (p8)
  );

  arb4_rr #(.MAX_BURST(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .req       (req1),
    .gnt       (gnt1),
    .gnt_valid (v1),
    .gnt_id    (id1),
    .preempt   (p1)
  );

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [7:0] got, want;
      e = q.pop_front();
      got  = e.d ? {gnt1, v1, id1, p1} : {gnt8, v8, id8, p8};
      want = {e.g, e.v, e.id, e.p};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got gnt=%b v=%b id=%0d p=%b want gnt=%b v=%b id=%0d p=%b",
          e.nm, got[7:4], got[3], got[2:1], got[0],
          want[7:4], want[3], want[2:1], want[0]);
      end
    end
  end

  task automatic push(input bit d, input logic [3:0] g, input logic v,
                      input logic [1:0] id, input logic p, input string nm);
    exp_t e;
    e.d = d; e.g = g; e.v = v; e.id = id; e.p = p; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic step(input bit d, input logic [3:0] r, input logic [3:0] g,
                      input logic [1:0] id, input logic p, input string nm);
    if (d) req1 = r;
    else req8 = r;
    @(posedge clk);
    #1;
    push(d, g, |g, id, p, nm);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    #1;
    rst = 1'b0;
    req8 = 4'b0000;
    req1 = 4'b0000;
    push(1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, nm);
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    // reset state, both instances
    push(1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, "rst8");
    push(1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, "rst1");
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;

    // test 1: async reset while gnt=0010
    step(0, 4'b0010, 4'b0010, 2'd1, 0, "t1_gnt1");
    @(posedge clk);
    #2;
    rst = 1'b0;
    push(1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, "t1_async_rst");
    @(negedge clk);
    #1;
    rst = 1'b1;
    step(0, 4'b1111, 4'b0001, 2'd0, 0, "t1_first");

    // test 2: single requester then idle
    do_reset("t2_rst");
    for (int i = 0; i < 3; i++) step(0, 4'b0100, 4'b0100, 2'd2, 0, "t2_hold");
    step(0, 4'b0000, 4'b0000, 2'd2, 0, "t2_idle");
    step(0, 4'b0000, 4'b0000, 2'd2, 0, "t2_idle2");

    // test 3: each owner releases after 2 cycles
    do_reset("t3_rst");
    step(0, 4'b1111, 4'b0001, 2'd0, 0, "t3_o0a");
    step(0, 4'b1111, 4'b0001, 2'd0, 0, "t3_o0b");
    step(0, 4'b1110, 4'b0010, 2'd1, 0, "t3_o1a");
    step(0, 4'b1110, 4'b0010, 2'd1, 0, "t3_o1b");
    step(0, 4'b1101, 4'b0100, 2'd2, 0, "t3_o2a");
    step(0, 4'b1101, 4'b0100, 2'd2, 0, "t3_o2b");
    step(0, 4'b1011, 4'b1000, 2'd3, 0, "t3_o3a");
    step(0, 4'b1011, 4'b1000, 2'd3, 0, "t3_o3b");
    step(0, 4'b0111, 4'b0001, 2'd0, 0, "t3_o0c");

    // test 4: burst limit with two requesters
    do_reset("t4_rst");
    for (int i = 0; i < 8; i++) step(0, 4'b0011, 4'b0001, 2'd0, 0, "t4_o0");
    for (int i = 0; i < 8; i++)
      step(0, 4'b0011, 4'b0010, 2'd1, (i == 0), "t4_o1");
    step(0, 4'b0011, 4'b0001, 2'd0, 1, "t4_back");
    step(0, 4'b0011, 4'b0001, 2'd0, 0, "t4_back2");

    // test 5: lone requester renews its burst
    do_reset("t5_rst");
    for (int i = 0; i < 20; i++) step(0, 4'b0001, 4'b0001, 2'd0, 0, "t5_lone");

    // test 6a: voluntary handover, no gap
    do_reset("t6_rst");
    step(0, 4'b0101, 4'b0001, 2'd0, 0, "t6_o0a");
    step(0, 4'b0101, 4'b0001, 2'd0, 0, "t6_o0b");
    step(0, 4'b0100, 4'b0100, 2'd2, 0, "t6_hand");
    step(0, 4'b0100, 4'b0100, 2'd2, 0, "t6_o2");

    // test 6b: MAX_BURST=1 rotation
    do_reset("t6b_rst");
    step(1, 4'b1111, 4'b0001, 2'd0, 0, "t6b_r0");
    step(1, 4'b1111, 4'b0010, 2'd1, 1, "t6b_r1");
    step(1, 4'b1111, 4'b0100, 2'd2, 1, "t6b_r2");
    step(1, 4'b1111, 4'b1000, 2'd3, 1, "t6b_r3");
    step(1, 4'b1111, 4'b0001, 2'd0, 1, "t6b_r4");
    step(1, 4'b1111, 4'b0010, 2'd1, 1, "t6b_r5");
    step(1, 4'b0010, 4'b0010, 2'd1, 0, "t6b_lone");
    step(1, 4'b0010, 4'b0010, 2'd1, 0, "t6b_lone2");

    repeat (4) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
